// File: rtl/mips_pkg.sv
// Shared constants for the MIPS execute stage: control-word bit positions,
// store-size encodings, divider state encoding and the store-lane formatter.
package mips_pkg;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_SLT   = 2;
  localparam int OP_SLTU  = 3;
  localparam int OP_AND   = 4;
  localparam int OP_OR    = 5;
  localparam int OP_XOR   = 6;
  localparam int OP_NOR   = 7;
  localparam int OP_SLL   = 8;
  localparam int OP_SRL   = 9;
  localparam int OP_SRA   = 10;
  localparam int OP_LUI   = 11;
  localparam int OP_LOAD  = 12;
  localparam int OP_STORE = 13;
  localparam int OP_SIZE_LO = 14;
  localparam int OP_SIZE_HI = 15;
  localparam int OP_MULT  = 16;
  localparam int OP_MULTU = 17;
  localparam int OP_DIV   = 18;
  localparam int OP_DIVU  = 19;
  localparam int OP_MFHI  = 27;
  localparam int OP_MFLO  = 28;
  localparam int OP_MTHI  = 29;
  localparam int OP_MTLO  = 30;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10
  } store_size_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] wdata;
  } store_fmt_t;

  // Replicates store data across lanes and selects the byte enables.
  function automatic store_fmt_t store_format(input logic [1:0]  size,
                                              input logic [1:0]  addr_lo,
                                              input logic [31:0] rt);
    store_fmt_t f;
    case (size)
      SIZE_HALF: begin
        f.wen   = addr_lo[1] ? 4'b1100 : 4'b0011;
        f.wdata = {2{rt[15:0]}};
      end
      SIZE_BYTE: begin
        f.wen   = 4'b0001 << addr_lo;
        f.wdata = {4{rt[7:0]}};
      end
      default: begin
        f.wen   = 4'b1111;
        f.wdata = rt;
      end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mips_divider.sv
// 32-iteration restoring divider on magnitudes with sign fix-up for signed mode.
// IDLE -> BUSY on start, 32 BUSY cycles, DONE until the result is acknowledged.
module mips_divider
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state, state_d;
  logic [4:0]  count;
  logic [31:0] rem_q, quo_q, dsr_q;
  logic        neg_q, neg_r;

  logic [31:0] dividend_mag, divisor_mag;
  logic [32:0] partial, diff;
  logic        ge;

  assign dividend_mag = (is_signed && dividend[31]) ? -dividend : dividend;
  assign divisor_mag  = (is_signed && divisor[31])  ? -divisor  : divisor;

  assign partial = {rem_q, quo_q[31]};
  assign diff    = partial - {1'b0, dsr_q};
  assign ge      = !diff[32];

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      DIV_IDLE: if (start)          state_d = DIV_BUSY;
      DIV_BUSY: if (count == 5'd31) state_d = DIV_DONE;
      DIV_DONE: if (ack)            state_d = DIV_IDLE;
      default:                      state_d = DIV_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      count <= '0;
    end else begin
      state <= state_d;
      count <= (state == DIV_BUSY) ? count + 5'd1 : 5'd0;
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on start before being observed.
  always_ff @(posedge clk) begin
    if (state == DIV_IDLE && start) begin
      rem_q <= '0;
      quo_q <= dividend_mag;
      dsr_q <= divisor_mag;
      neg_q <= is_signed && (dividend[31] ^ divisor[31]);
      neg_r <= is_signed && dividend[31];
    end else if (state == DIV_BUSY) begin
      rem_q <= ge ? diff[31:0] : partial[31:0];
      quo_q <= {quo_q[30:0], ge};
    end
  end

  assign busy      = (state == DIV_BUSY);
  assign done      = (state == DIV_DONE);
  assign quotient  = neg_q ? -quo_q : quo_q;
  assign remainder = neg_r ? -rem_q : rem_q;

endmodule

// File: rtl/mips_execute_stage.sv
// MIPS execute stage: ALU, multiplier, HI/LO registers, divider control,
// store formatting and the valid/allowin handshake toward the memory stage.
module mips_execute_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] de_out_op,
  input  logic [4:0]  de_rf_waddr,
  input  logic [31:0] de_alu_src1,
  input  logic [31:0] de_alu_src2,
  input  logic [31:0] de_rf_rdata_2,
  input  logic [31:0] de_pc,
  input  logic [31:0] de_instruction,
  input  logic        de_valid_ready_go,
  input  logic        mem_allowin,
  output logic [31:0] ex_out_op,
  output logic [4:0]  ex_rf_waddr,
  output logic [31:0] ex_out_value,
  output logic [31:0] ex_rf_rdata_2,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_instruction,
  output logic [31:0] ex_hi_value,
  output logic [31:0] ex_lo_value,
  output logic        ex_valid,
  output logic        ex_allowin,
  output logic        ex_valid_ready_go,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata
);

  logic [31:0] op_q, src1_q, src2_q, rt_q, pc_q, inst_q;
  logic [4:0]  waddr_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_d, lo_d;

  logic        ex_ready_go, fire;
  logic        is_load, is_store, is_div, div_by_zero;
  logic        div_start, div_busy, div_done;
  logic [31:0] div_quo, div_rem;

  // Handshake and payload latch
  assign ex_allowin        = !ex_valid || (ex_ready_go && mem_allowin);
  assign ex_valid_ready_go = ex_valid && ex_ready_go;
  assign fire              = ex_valid_ready_go && mem_allowin;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      op_q     <= '0;
      waddr_q  <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      rt_q     <= '0;
      pc_q     <= '0;
      inst_q   <= '0;
    end else begin
      if (ex_allowin) ex_valid <= de_valid_ready_go;
      if (de_valid_ready_go && ex_allowin) begin
        op_q    <= de_out_op;
        waddr_q <= de_rf_waddr;
        src1_q  <= de_alu_src1;
        src2_q  <= de_alu_src2;
        rt_q    <= de_rf_rdata_2;
        pc_q    <= de_pc;
        inst_q  <= de_instruction;
      end
    end
  end

  assign is_load     = op_q[OP_LOAD];
  assign is_store    = op_q[OP_STORE];
  assign is_div      = op_q[OP_DIV] || op_q[OP_DIVU];
  assign div_by_zero = (src2_q == 32'd0);
  assign div_start   = ex_valid && is_div && !div_by_zero && !div_busy && !div_done;
  assign ex_ready_go = !is_div || div_by_zero || div_done;

  mips_divider u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (op_q[OP_DIV]),
    .dividend  (src1_q),
    .divisor   (src2_q),
    .ack       (fire),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // ALU: one-hot select, unselected units contribute zero
  logic [31:0] addr, sum, diff, alu_res;
  assign sum  = src1_q + src2_q;
  assign diff = src1_q - src2_q;
  assign addr = sum;

  always_comb begin
    alu_res = '0;
    if (op_q[OP_ADD])  alu_res |= sum;
    if (op_q[OP_SUB])  alu_res |= diff;
    if (op_q[OP_SLT])  alu_res |= {31'd0, $signed(src1_q) < $signed(src2_q)};
    if (op_q[OP_SLTU]) alu_res |= {31'd0, src1_q < src2_q};
    if (op_q[OP_AND])  alu_res |= src1_q & src2_q;
    if (op_q[OP_OR])   alu_res |= src1_q | src2_q;
    if (op_q[OP_XOR])  alu_res |= src1_q ^ src2_q;
    if (op_q[OP_NOR])  alu_res |= ~(src1_q | src2_q);
    if (op_q[OP_SLL])  alu_res |= src2_q << src1_q[4:0];
    if (op_q[OP_SRL])  alu_res |= src2_q >> src1_q[4:0];
    if (op_q[OP_SRA])  alu_res |= $unsigned($signed(src2_q) >>> src1_q[4:0]);
    if (op_q[OP_LUI])  alu_res |= {src2_q[15:0], 16'h0000};
  end

  always_comb begin
    if (op_q[OP_MFHI])            ex_out_value = hi_q;
    else if (op_q[OP_MFLO])       ex_out_value = lo_q;
    else if (is_load || is_store) ex_out_value = addr;
    else                          ex_out_value = alu_res;
  end

  // Multiplier: operands widened to 64 bits so the truncated product is exact
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{src1_q[31]}}, src1_q} * {{32{src2_q[31]}}, src2_q};
  assign prod_u = {32'd0, src1_q} * {32'd0, src2_q};

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (op_q[OP_MULT])            {hi_d, lo_d} = prod_s;
    else if (op_q[OP_MULTU])      {hi_d, lo_d} = prod_u;
    else if (is_div && !div_by_zero) begin
      hi_d = div_rem;
      lo_d = div_quo;
    end
    if (op_q[OP_MTHI]) hi_d = src1_q;
    if (op_q[OP_MTLO]) lo_d = src1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (fire) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign ex_hi_value = hi_d;
  assign ex_lo_value = lo_d;

  // Data SRAM request: one per memory op, only on the fire cycle
  store_fmt_t fmt;
  assign fmt             = store_format(op_q[OP_SIZE_HI:OP_SIZE_LO], addr[1:0], rt_q);
  assign data_sram_en    = fire && (is_load || is_store);
  assign data_sram_wen   = is_store ? fmt.wen : 4'b0000;
  assign data_sram_wdata = fmt.wdata;
  assign data_sram_addr  = addr;

  assign ex_out_op      = op_q;
  assign ex_rf_waddr    = waddr_q;
  assign ex_rf_rdata_2  = rt_q;
  assign ex_pc          = pc_q;
  assign ex_instruction = inst_q;

endmodule

// File: tb/tb_mips_execute_stage.sv
// Directed self-checking bench for mips_execute_stage: ALU, stores, HI/LO,
// divide latency, divide-by-zero, memory-stage stall and reset mid-divide.
module tb_mips_execute_stage;

  localparam logic [31:0] OP_ADD   = 32'h0000_0001;
  localparam logic [31:0] OP_SLT   = 32'h0000_0004;
  localparam logic [31:0] OP_SLTU  = 32'h0000_0008;
  localparam logic [31:0] OP_NOR   = 32'h0000_0080;
  localparam logic [31:0] OP_SRA   = 32'h0000_0400;
  localparam logic [31:0] OP_LUI   = 32'h0000_0800;
  localparam logic [31:0] OP_LOAD  = 32'h0000_1000;
  localparam logic [31:0] OP_STORE = 32'h0000_2000;
  localparam logic [31:0] SZ_HALF  = 32'h0000_4000;
  localparam logic [31:0] SZ_BYTE  = 32'h0000_8000;
  localparam logic [31:0] OP_MULT  = 32'h0001_0000;
  localparam logic [31:0] OP_MULTU = 32'h0002_0000;
  localparam logic [31:0] OP_DIV   = 32'h0004_0000;
  localparam logic [31:0] OP_DIVU  = 32'h0008_0000;
  localparam logic [31:0] OP_MFHI  = 32'h0800_0000;
  localparam logic [31:0] OP_MFLO  = 32'h1000_0000;
  localparam logic [31:0] OP_MTHI  = 32'h2000_0000;
  localparam logic [31:0] OP_MTLO  = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] de_out_op, de_alu_src1, de_alu_src2, de_rf_rdata_2, de_pc, de_instruction;
  logic [4:0]  de_rf_waddr;
  logic        de_valid_ready_go, mem_allowin;
  logic [31:0] ex_out_op, ex_out_value, ex_rf_rdata_2, ex_pc, ex_instruction;
  logic [31:0] ex_hi_value, ex_lo_value;
  logic [4:0]  ex_rf_waddr;
  logic        ex_valid, ex_allowin, ex_valid_ready_go, data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata;

  int vectors = 0;
  int miscompares = 0;
  int icount = 0;
  int lat;

  mips_execute_stage dut (
    .clk               (clk),
    .rst               (rst),
    .de_out_op         (de_out_op),
    .de_rf_waddr       (de_rf_waddr),
    .de_alu_src1       (de_alu_src1),
    .de_alu_src2       (de_alu_src2),
    .de_rf_rdata_2     (de_rf_rdata_2),
    .de_pc             (de_pc),
    .de_instruction    (de_instruction),
    .de_valid_ready_go (de_valid_ready_go),
    .mem_allowin       (mem_allowin),
    .ex_out_op         (ex_out_op),
    .ex_rf_waddr       (ex_rf_waddr),
    .ex_out_value      (ex_out_value),
    .ex_rf_rdata_2     (ex_rf_rdata_2),
    .ex_pc             (ex_pc),
    .ex_instruction    (ex_instruction),
    .ex_hi_value       (ex_hi_value),
    .ex_lo_value       (ex_lo_value),
    .ex_valid          (ex_valid),
    .ex_allowin        (ex_allowin),
    .ex_valid_ready_go (ex_valid_ready_go),
    .data_sram_en      (data_sram_en),
    .data_sram_wen     (data_sram_wen),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction from decode and returns once it sits in execute.
  task automatic issue(input logic [31:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] rt);
    int t;
    de_out_op         = op;
    de_alu_src1       = a;
    de_alu_src2       = b;
    de_rf_rdata_2     = rt;
    de_rf_waddr       = 5'(icount + 1);
    de_pc             = 32'hBFC0_0000 + 32'(icount * 4);
    de_instruction    = de_pc ^ 32'hFFFF_0000;
    de_valid_ready_go = 1'b1;
    t = 0;
    while (!ex_allowin && t < 100) begin
      step();
      t++;
    end
    check("issue_allowin", {31'd0, ex_allowin}, 32'd1);
    step();
    de_valid_ready_go = 1'b0;
    icount++;
  endtask

  // Counts cycles from latch until the stage is ready to fire; returns latch-to-fire edges.
  task automatic wait_fire(output int n);
    n = 0;
    while (!(ex_valid_ready_go && mem_allowin) && n < 200) begin
      check("div_allowin_low", {31'd0, ex_allowin}, 32'd0);
      step();
      n++;
    end
    n = n + 1;
  endtask

  initial begin
    rst = 1'b1;
    mem_allowin = 1'b1;
    de_valid_ready_go = 1'b0;
    de_out_op = '0; de_alu_src1 = '0; de_alu_src2 = '0; de_rf_rdata_2 = '0;
    de_rf_waddr = '0; de_pc = '0; de_instruction = '0;
    repeat (2) step();
    rst = 1'b0;

    check("rst_valid",   {31'd0, ex_valid},   32'd0);
    check("rst_allowin", {31'd0, ex_allowin}, 32'd1);
    check("rst_en",      {31'd0, data_sram_en}, 32'd0);
    check("rst_wen",     {28'd0, data_sram_wen}, 32'd0);
    check("rst_hi",      ex_hi_value, 32'd0);
    check("rst_lo",      ex_lo_value, 32'd0);
    check("rst_value",   ex_out_value, 32'd0);

    // ALU
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0);
    check("add_value", ex_out_value, 32'h8000_0000);
    check("add_rdy",   {31'd0, ex_valid_ready_go}, 32'd1);
    check("add_waddr", {27'd0, ex_rf_waddr}, 32'd1);
    check("add_pc",    ex_pc, 32'hBFC0_0000);
    check("add_inst",  ex_instruction, 32'h403F_0000);
    check("add_en",    {31'd0, data_sram_en}, 32'd0);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h0);
    check("slt", ex_out_value, 32'd1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0);
    check("sltu", ex_out_value, 32'd0);
    issue(OP_SRA, 32'd4, 32'h8000_0000, 32'h0);
    check("sra", ex_out_value, 32'hF800_0000);
    issue(OP_LUI, 32'h0, 32'h0000_1234, 32'h0);
    check("lui", ex_out_value, 32'h1234_0000);
    issue(OP_NOR, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0);
    check("nor", ex_out_value, 32'h0000_0F0F);

    // Stores and loads
    issue(OP_STORE | SZ_BYTE, 32'h1000, 32'h3, 32'h1234_5678);
    check("sb_en",    {31'd0, data_sram_en}, 32'd1);
    check("sb_wen",   {28'd0, data_sram_wen}, 32'h8);
    check("sb_wdata", data_sram_wdata, 32'h7878_7878);
    check("sb_addr",  data_sram_addr, 32'h0000_1003);
    check("sb_rt",    ex_rf_rdata_2, 32'h1234_5678);
    step();
    check("sb_en_once", {31'd0, data_sram_en}, 32'd0);
    check("sb_drained", {31'd0, ex_valid}, 32'd0);
    issue(OP_LOAD, 32'h100, 32'h4, 32'h0);
    check("lw_en",   {31'd0, data_sram_en}, 32'd1);
    check("lw_wen",  {28'd0, data_sram_wen}, 32'h0);
    check("lw_addr", data_sram_addr, 32'h0000_0104);
    issue(OP_STORE, 32'h200, 32'h0, 32'hDEAD_BEEF);
    check("sw_wen",   {28'd0, data_sram_wen}, 32'hF);
    check("sw_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    step();

    // Store held by the memory stage for 5 cycles
    mem_allowin = 1'b0;
    issue(OP_STORE | SZ_HALF, 32'h2000, 32'h2, 32'hAABB_CCDD);
    for (int i = 0; i < 5; i++) begin
      check("stall_en",      {31'd0, data_sram_en}, 32'd0);
      check("stall_allowin", {31'd0, ex_allowin}, 32'd0);
      step();
    end
    mem_allowin = 1'b1;
    #1;
    check("sh_en",    {31'd0, data_sram_en}, 32'd1);
    check("sh_wen",   {28'd0, data_sram_wen}, 32'hC);
    check("sh_wdata", data_sram_wdata, 32'hCCDD_CCDD);
    step();
    check("sh_en_once", {31'd0, data_sram_en}, 32'd0);

    // Multiply and HI/LO moves
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'h0);
    check("mult_hi", ex_hi_value, 32'hFFFF_FFFF);
    check("mult_lo", ex_lo_value, 32'hFFFF_FFFA);
    issue(OP_MFLO, 32'h0, 32'h0, 32'h0);
    check("mflo_after_mult", ex_out_value, 32'hFFFF_FFFA);
    issue(OP_MFHI, 32'h0, 32'h0, 32'h0);
    check("mfhi_after_mult", ex_out_value, 32'hFFFF_FFFF);
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0);
    check("multu_hi", ex_hi_value, 32'h0000_0002);
    check("multu_lo", ex_lo_value, 32'hFFFF_FFFA);

    // Signed divide: -7 / 2
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0);
    wait_fire(lat);
    check("div_latency", 32'(lat), 32'd34);
    check("div_lo", ex_lo_value, 32'hFFFF_FFFD);
    check("div_hi", ex_hi_value, 32'hFFFF_FFFF);
    issue(OP_MFLO, 32'h0, 32'h0, 32'h0);
    check("mflo_after_div", ex_out_value, 32'hFFFF_FFFD);

    // Divide by zero leaves HI/LO alone and completes at once
    issue(OP_DIVU, 32'd5, 32'd0, 32'h0);
    check("div0_rdy", {31'd0, ex_valid_ready_go}, 32'd1);
    check("div0_hi",  ex_hi_value, 32'hFFFF_FFFF);
    check("div0_lo",  ex_lo_value, 32'hFFFF_FFFD);
    issue(OP_MFHI, 32'h0, 32'h0, 32'h0);
    check("mfhi_after_div0", ex_out_value, 32'hFFFF_FFFF);

    issue(OP_MTHI, 32'hCAFE_F00D, 32'h0, 32'h0);
    check("mthi", ex_hi_value, 32'hCAFE_F00D);
    issue(OP_MTLO, 32'h0BAD_BEEF, 32'h0, 32'h0);
    check("mtlo", ex_lo_value, 32'h0BAD_BEEF);
    issue(OP_MFHI, 32'h0, 32'h0, 32'h0);
    check("mfhi_after_mthi", ex_out_value, 32'hCAFE_F00D);
    step();

    // Reset in the middle of a divide
    issue(OP_DIV, 32'd100, 32'd7, 32'h0);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstdiv_valid",   {31'd0, ex_valid}, 32'd0);
    check("rstdiv_allowin", {31'd0, ex_allowin}, 32'd1);
    check("rstdiv_hi",      ex_hi_value, 32'd0);
    check("rstdiv_lo",      ex_lo_value, 32'd0);

    // A fresh divide after reset takes the full latency (divider back in IDLE)
    issue(OP_DIVU, 32'h8000_0000, 32'd3, 32'h0);
    wait_fire(lat);
    check("divu_latency", 32'(lat), 32'd34);
    check("divu_lo", ex_lo_value, 32'h2AAA_AAAA);
    check("divu_hi", ex_hi_value, 32'h0000_0002);
    step();
    check("divu_drained", {31'd0, ex_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_execute_stage.md
# mips_execute_stage

Third stage of the five-stage MIPS pipeline, between decode and memory. Latches decoded operands from decode and computes ALU results, HI/LO multiply and divide results, and load/store addresses. Issues exactly one data-SRAM request per memory instruction. Forwards op, destination, result, store data, PC/instruction and HI/LO to the memory stage through the valid/allowin handshake.

## Interface
- Parameters: none (op-field bit positions are fixed constants in `mips_pkg`)
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `de_out_op` in 32: decoded control word (bit map below)
- `de_rf_waddr` in 5: destination register number
- `de_alu_src1`, `de_alu_src2` in 32 each: operands already muxed by decode (immediate/shamt/PC applied)
- `de_rf_rdata_2` in 32: rt value, used as store data
- `de_pc`, `de_instruction` in 32 each: PC and instruction code at decode
- `de_valid_ready_go` in 1: decode holds a valid, finished instruction
- `mem_allowin` in 1: memory stage can accept
- `ex_out_op`, `ex_rf_waddr`, `ex_out_value`, `ex_rf_rdata_2`, `ex_pc`, `ex_instruction` out: registered payload to memory stage
- `ex_hi_value`, `ex_lo_value` out 32: HI/LO as seen by this instruction, after its own update
- `ex_valid` out 1; `ex_allowin` out 1; `ex_valid_ready_go` out 1
- `data_sram_en` out 1; `data_sram_wen` out 4; `data_sram_addr` out 32; `data_sram_wdata` out 32

## Operation
- Op bit map:
  - [11:0] ALU one-hot: ADD, SUB, SLT, SLTU, AND, OR, XOR, NOR, SLL, SRL, SRA, LUI
  - [12] load (WBMux); [13] store; [15:14] store size: 00 word, 01 half, 10 byte
  - [16] MULT; [17] MULTU; [18] DIV; [19] DIVU
  - [26:20] load one-hot: passed through untouched
  - [27] MFHI; [28] MFLO; [29] MTHI; [30] MTLO; [31] reserved, passed through
- ALU arithmetic:
  - ADD/SUB are 32-bit wrap; there is no overflow trap.
  - SLT is signed; SLTU is unsigned.
  - Shifts use `src1[4:0]` as the amount and `src2` as the value.
  - LUI gives `{src2[15:0],16'h0}`.
- `ex_out_value`:
  - MFHI: HI
  - MFLO: LO
  - Otherwise: ALU result. For load/store this is the address `src1+src2`.
- MULT/MULTU: single-cycle 64-bit product; {HI,LO} <= product.
- DIV/DIVU:
  - 32-iteration restoring divide on magnitudes, with sign correction for DIV.
  - The quotient takes the dividend's sign XOR the divisor's sign; the remainder takes the dividend's sign.
  - LO <= quotient; HI <= remainder.
  - Divisor 0: HI/LO unchanged, the instruction completes in 1 cycle, no exception.
- MTHI/MTLO: HI or LO <= `src1`.
- HI/LO architectural registers live here. They update only on the fire cycle (`ex_valid_ready_go && mem_allowin`).
- Store data and enables:
  - Word: `wdata = rt`, `wen = 1111`
  - Half: `wdata = {2{rt[15:0]}}`, `wen = addr[1] ? 1100 : 0011`
  - Byte: `wdata = {4{rt[7:0]}}`, `wen = 0001 << addr[1:0]`
  - Loads: `wen = 0000`
- `data_sram_en = fire && (load || store)`. Address is the ALU address.
- Divider FSM (sub-module):
  - IDLE -> BUSY on `ex_valid && div_op && divisor != 0`
  - BUSY counts 32 cycles, then -> DONE
  - DONE -> IDLE on fire
- `ex_ready_go` = non-div op, or divisor 0, or FSM in DONE.

## Timing
- Handshake:
  - `ex_allowin = !ex_valid || ex_ready_go && mem_allowin`
  - `ex_valid_ready_go = ex_valid && ex_ready_go`
  - On `ex_allowin`: `ex_valid <= de_valid_ready_go`
  - On `de_valid_ready_go && ex_allowin`: all payload registers load.
- Latency:
  - Non-div instructions: 1 cycle in stage.
  - DIV/DIVU: 34 cycles from latch to fire (1 start + 32 iterate + 1 done).
  - Stall thereafter if `mem_allowin` is low; the result is held stable.
- SRAM read data returns the cycle after `data_sram_en`, aligned with the memory stage.
- While `mem_allowin` is low, no SRAM request is issued and HI/LO do not change. The op stays in place, so each op is issued exactly once.
- Reset values:
  - 0: `ex_valid`, HI, LO, all payload registers, `data_sram_en`, `wen`
  - FSM: IDLE
  - `ex_allowin` = 1
- Reset during BUSY aborts the divide. No HI/LO write occurs.
- An MFHI/MFLO immediately following MULT/DIV sees the updated value: HI/LO are written at the producer's fire, one cycle before the consumer is in execute.

## Structure
- `mips_pkg` holds:
  - op bit-index localparams (ALU one-hot positions, load/store/size, MULT..MTLO)
  - store-size encodings
  - divider state encoding (IDLE/BUSY/DONE)
- Sub-module `mips_divider`:
  - Inputs: clk, rst, start, signed, dividend, divisor, ack.
  - Outputs: busy, done, quotient, remainder.
- The stage itself holds the ALU, multiplier, HI/LO registers, store formatter and handshake.

## Test plan
- ADD `src1=0x7FFFFFFF`, `src2=1` -> `ex_out_value=0x80000000`, 1 cycle; SLT `0xFFFFFFFF` vs `1` -> `1`; SLTU -> `0`.
- SB with `rt=0x12345678`, address `0x1003` -> `wen=1000`, `wdata=0x78787878`, `en` high for exactly one cycle.
- MULT `0xFFFFFFFE`×`3` -> HI=`0xFFFFFFFF`, LO=`0xFFFFFFFA`; the following MFLO returns `0xFFFFFFFA`.
- DIV `-7`/`2` -> LO=`0xFFFFFFFD`, HI=`0xFFFFFFFF`; fire exactly 34 cycles after latch; `ex_allowin` low throughout.
- DIVU by 0 -> HI/LO unchanged, fire next cycle.
- `mem_allowin` low for 5 cycles during a store -> no SRAM request until release, then exactly one. Separately, assert `rst` mid-divide -> `ex_valid=0`, HI=LO=0, FSM IDLE.
